// File: rtl/inst_mem_pkg.sv
// Shared types for the loadable instruction memory.
// State encoding, NOP word and fetch error causes.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    LOAD
  } state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_BOTH  = 2'b11
  } err_cause_t;

  // Misalignment in bit 0, out-of-range in bit 1.
  function automatic err_cause_t classify(
    input logic [1:0] low,
    input logic       high_set
  );
    return err_cause_t'({high_set, low != 2'b00});
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W RAM, registered read port and one write port.
// Contents are never reset.
module inst_mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write when strobed; read the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Loadable instruction memory with fetch handshake,
// programmable wait states, stall hold and a load port.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int                 ADDR_W      = 6,
  parameter int                 DATA_W      = 32,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0]  NOP_WORD    = DATA_W'(MIPS_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic              busy,
  input  logic              ld_en,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt_q, cnt_nx;
  logic [ADDR_W-1:0] idx_q, fidx, raddr;
  err_cause_t        cause_q, fcause;
  logic [DATA_W-1:0] rdata, hold_q, resp_word;
  logic              accept, we, ld_done_q;

  assign fidx   = fetch_addr[ADDR_W+1:2];
  assign fcause = classify(fetch_addr[1:0],
                           |fetch_addr[31:ADDR_W+2]);

  assign accept = fetch_req & ~ld_en &
                  ((state == IDLE) |
                   ((state == RESP) & ~stall));

  // Keep reading the captured index so rdata is stable
  // through WAIT and stalled RESP cycles.
  assign raddr = accept ? fidx : idx_q;

  // A write coinciding with reset is dropped.
  assign we = (state == LOAD) & ld_we & ~rst;

  inst_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(ld_addr),
    .wdata(ld_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign resp_word = (cause_q == ERR_NONE) ? rdata
                                           : NOP_WORD;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (ld_en) begin
          state_nx = LOAD;
        end else if (accept) begin
          state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_nx   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_nx = RESP;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (!stall) begin
          if (accept) begin
            state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_nx   = 4'd0;
          end else if (ld_en) begin
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      LOAD: begin
        if (!ld_en) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Capture index and error cause of an accepted fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      cause_q <= ERR_NONE;
    end else if (accept) begin
      idx_q   <= fidx;
      cause_q <= fcause;
    end
  end

  // Remember the last presented word for non-RESP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= NOP_WORD;
    end else if (state == RESP) begin
      hold_q <= resp_word;
    end
  end

  // One-cycle pulse after leaving LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= (state == LOAD) & ~ld_en;
    end
  end

  assign inst       = (state == RESP) ? resp_word : hold_q;
  assign inst_valid = (state == RESP);
  assign fetch_err  = (state == RESP) & (cause_q != ERR_NONE);
  assign busy       = (state == WAIT) | (state == LOAD);
  assign ld_done    = ld_done_q;

endmodule

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
Parametrised, clocked instruction memory for the pipelined MIPS core. It replaces a fixed combinational ROM with a loadable RAM.
- Fetch side: req/valid handshake, programmable wait states and stall hold.
- Debug/boot side: a load port that writes program words at run time.
- Error handling: misaligned and out-of-range fetches are flagged and return a NOP.

Parameters:
ADDR_W, 6, word-index width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction width
WAIT_CYCLES, 0, extra wait states between fetch accept and response (0..15)
NOP_WORD, 32'h00000000, word returned on error/reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch request from IF stage
fetch_addr  in  32  byte address of the fetch
stall  in  1  pipeline stall; holds the current response
inst  out  DATA_W  fetched instruction
inst_valid  out  1  inst holds a valid response
fetch_err  out  1  response is for a misaligned or out-of-range address
busy  out  1  high in WAIT or LOAD; fetch_req is not accepted
ld_en  in  1  load-mode request
ld_we  in  1  load write strobe
ld_addr  in  ADDR_W  word index for the load write
ld_data  in  DATA_W  load write data
ld_done  out  1  one-cycle pulse on exit from LOAD

Behaviour:
- Reset (asynchronous): state=IDLE, inst=NOP_WORD, inst_valid=0, fetch_err=0, busy=0, ld_done=0, wait counter=0.
- Memory contents are not affected by reset.
- States: IDLE, WAIT, RESP, LOAD.
- Accept: a fetch is accepted in IDLE, or in RESP with stall=0, when fetch_req=1 and ld_en=0.
  - Capture idx = fetch_addr[ADDR_W+1:2].
  - Capture err = (fetch_addr[1:0]!=0) | (fetch_addr[31:ADDR_W+2]!=0).
- WAIT_CYCLES=0: next state is RESP. inst_valid=1 one cycle after accept; throughput is one fetch per cycle back-to-back.
- WAIT_CYCLES=N>0: go to WAIT, count N cycles with busy=1 and inst_valid=0, then RESP. Total latency is N+1 cycles.
- RESP outputs: inst=mem[idx] and fetch_err=0 when err=0; otherwise inst=NOP_WORD and fetch_err=1.
- RESP with stall=1: hold inst, inst_valid and fetch_err unchanged. fetch_req is ignored.
- RESP with stall=0:
  - accept new fetch if offered;
  - else if ld_en=1, go to LOAD;
  - else go to IDLE with inst_valid=0 (inst keeps its last value).
- IDLE with ld_en=1: go to LOAD. Load wins over a simultaneous fetch_req.
- LOAD:
  - busy=1, inst_valid=0.
  - Each cycle with ld_we=1 writes ld_data to mem[ld_addr].
  - ld_en=0 returns to IDLE, with ld_done=1 for exactly that one cycle.
  - ld_we is ignored outside LOAD.
- Memory read is synchronous (registered), 1R1W.
  - A write in LOAD followed by a fetch of the same index returns the new data.
  - No read/write overlap exists because fetches are blocked in LOAD.
- WAIT is not interruptible by ld_en. A load request is served after the response completes.
- Reset asserted in any state, including mid-WAIT or mid-LOAD, aborts immediately to reset values.
  - A write in progress that cycle is dropped.
- Address wraps are not allowed: any address bit above ADDR_W+1 set is an error.

Decomposition:
- Package inst_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP, LOAD);
  - MIPS_NOP constant (32'h00000000);
  - error-cause encoding.
- One sub-module, inst_mem_array: parametrised DEPTH x DATA_W synchronous-read single-write RAM (clk, we, waddr, wdata, raddr, rdata). It has no reset.

Test Plan:
1. Load, then fetch (WAIT_CYCLES=0).
   - Stimulus: ld_en=1, write mem[1]=32'h14000801 and mem[2]=32'h14002422, ld_en=0.
   - Required: ld_done pulses once. fetch_addr=0x4 gives inst=32'h14000801, inst_valid=1 next cycle. A back-to-back fetch of 0x8 gives 32'h14002422 the following cycle.
2. Misaligned and out-of-range fetches.
   - fetch_addr=0x6 -> inst=0, fetch_err=1.
   - fetch_addr=0x100 with ADDR_W=6 -> inst=0, fetch_err=1.
   - fetch_addr=0xFC -> fetch_err=0.
3. Stall hold.
   - Response 32'h00100c41 with stall=1 for 3 cycles while fetch_req targets 0x4.
   - Required: inst stays 32'h00100c41 and inst_valid stays 1; the new fetch is accepted only when stall=0.
4. Wait states (WAIT_CYCLES=3).
   - Required: busy=1 for 3 cycles after accept; inst_valid rises on cycle 4. fetch_req during WAIT is ignored.
5. Load/fetch priority.
   - Stimulus: ld_en and fetch_req both asserted in IDLE.
   - Required: enter LOAD, busy=1, no inst_valid. After ld_en drops, the fetch is accepted the next cycle.
6. Asynchronous reset mid-operation.
   - Stimulus: rst pulsed mid-WAIT and mid-LOAD.
   - Required: outputs return immediately to reset values. Memory contents written before the reset are intact on the next fetch.
